instr_loader: RTL and testbench
===============================

# instr_loader

Boot-time program loader that writes instruction memory from the host side while the core only ever reads it. It accepts a little-endian byte stream (word count, program words, checksum) over a valid/ready interface and assembles 32-bit words. Each word is written to the instruction-memory write port at consecutive word addresses. The core is held in reset until a complete, checksum-verified image has been written.

## Interface
- D_WIDTH, 32, data and address width of the instruction-memory write port
- ADDR_BASE, 32'h0, byte address of the first program word
- MEM_WORDS, 256, instruction-memory depth in words; largest accepted word count
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  asynchronous, active-low reset (asserted at 0)
- byte_valid  input  1  byte_data is valid this cycle
- byte_data  input  8  stream byte
- byte_ready  output  1  loader accepts a byte this cycle
- wr_en  output  1  one-cycle instruction-memory write strobe
- wr_addr  output  D_WIDTH  byte address of the write (word aligned)
- wr_data  output  D_WIDTH  word to write
- cpu_rst  output  1  active-high reset to the core; released only when the load succeeds
- done  output  1  image loaded and verified (sticky)
- err  output  1  load failed (sticky)

## Operation
- A byte is accepted when byte_valid && byte_ready. Words are little-endian: the first accepted byte goes to [7:0] and the fourth to [31:24]. A 2-bit byte counter selects the lane.
- Stream format: 4-byte count N, then N words of 4 bytes each, then a 4-byte checksum C. C is the sum of all N words, modulo 2^32.
- FSM states: HEADER, LOAD, CSUM, DONE, ERROR.
- HEADER: collect N.
  - On the 4th byte, if N > MEM_WORDS, go to ERROR.
  - Else if N == 0, go to CSUM.
  - Else go to LOAD with word index i = 0 and running sum S = 0.
- LOAD: on each 4th byte:
  - Issue a write of the assembled word W to ADDR_BASE + 4*i.
  - Update S += W (wraps mod 2^32) and increment i.
  - When i reaches N, go to CSUM.
- CSUM: collect C. On the 4th byte, go to DONE if C == S, else ERROR.
- DONE and ERROR are terminal until reset. No further bytes are accepted and no further writes occur.
- byte_ready = 1 in HEADER, LOAD and CSUM; 0 in DONE and ERROR.
- cpu_rst = 1 in every state except DONE.
- done = 1 only in DONE; err = 1 only in ERROR.
- Writes from a load that later fails the checksum are not undone. err together with cpu_rst high prevents execution.

## Timing
- Reset values: byte_ready 1 (state HEADER); wr_en 0; wr_addr ADDR_BASE; wr_data 0; cpu_rst 1; done 0; err 0. The byte counter, i, S and the assembly register are all 0.
- Reset asserted mid-load clears all state asynchronously; the next accepted byte is treated as byte 0 of a new header.
- wr_en, wr_addr and wr_data are registered. They are valid in the cycle after the edge that accepts the 4th byte of a program word, and wr_en is high for exactly one cycle.
- Back-to-back full-rate input gives one write every 4 cycles, so writes never overlap.
- done/err and cpu_rst change in the cycle after the edge accepting the 4th checksum byte.
- For an oversize N, err asserts in the cycle after the 4th header byte, and no write is issued.
- byte_valid may drop at any time with no timeout. Partial-word state is held indefinitely while byte_valid is low.
- byte_ready is combinational from state only and never depends on byte_valid.
- byte_data is ignored in any cycle without acceptance.

## Test plan
- Normal load:
  - Stimulus: N=2, words 0x00500093 and 0x00100113, C=0x006001A6, streamed at full rate.
  - Required response: writes (0x0, 0x00500093) and (0x4, 0x00100113), each a one-cycle wr_en exactly 4 cycles apart; then done=1 and cpu_rst=0 one cycle after the last C byte; byte_ready=0 thereafter.
- Empty image:
  - Stimulus: N=0, C=0.
  - Required response: no wr_en; done=1, cpu_rst=0.
- Bad checksum:
  - Stimulus: the normal-load stream with C=0x006001A7.
  - Required response: both writes occur; err=1, done=0, cpu_rst stays 1; extra bytes are not accepted.
- Oversize:
  - Stimulus: N=MEM_WORDS+1 (257).
  - Required response: err=1 one cycle after the 4th header byte; wr_en never asserts.
- Reset mid-load:
  - Stimulus: assert rst low after 6 bytes of the normal stream (between edges), then send the full normal stream.
  - Required response: all outputs return to their reset values immediately; the second load completes exactly as in the normal-load case.
- Gapped input:
  - Stimulus: the normal stream with byte_valid low on random cycles, including within words.
  - Required response: identical write addresses and data, and done=1.

Source files
------------

// File: rtl/instr_loader_if.sv
// Loader-side bus: incoming byte stream (valid/ready) and the instruction-memory write port.
interface instr_loader_if #(
  parameter int D_WIDTH = 32
);
  logic               byte_valid;
  logic [7:0]         byte_data;
  logic               byte_ready;
  logic               wr_en;
  logic [D_WIDTH-1:0] wr_addr;
  logic [D_WIDTH-1:0] wr_data;

  // Host side: drives the stream and observes the memory writes.
  modport master (
    output byte_valid, byte_data,
    input  byte_ready, wr_en, wr_addr, wr_data
  );

  // Loader side.
  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/instr_loader.sv
// Boot loader: parses a little-endian stream (count, program words, checksum), writes each
// word to instruction memory, and releases the core only after the checksum matches.
module instr_loader #(
  parameter int                 D_WIDTH   = 32,
  parameter logic [D_WIDTH-1:0] ADDR_BASE = '0,
  parameter int                 MEM_WORDS = 256
) (
  input  logic          clk,
  input  logic          rst,
  instr_loader_if.slave bus,
  output logic          cpu_rst,
  output logic          done,
  output logic          err
);
  localparam int IW = $clog2(MEM_WORDS + 1);

  typedef enum logic [2:0] {HEADER, LOAD, CSUM, DONE, ERROR} state_t;

  state_t        state;
  logic [1:0]    byte_cnt;
  logic [23:0]   asm_lo;   // lanes 0..2; lane 3 is taken straight from byte_data
  logic [IW-1:0] count;
  logic [IW-1:0] idx;
  logic [31:0]   sum;

  logic          accept;
  logic          word_done;
  logic [31:0]   word;
  logic [IW-1:0] idx_next;

  assign bus.byte_ready = (state == HEADER) || (state == LOAD) || (state == CSUM);
  assign accept         = bus.byte_valid && bus.byte_ready;
  assign word_done      = accept && (byte_cnt == 2'd3);
  assign word           = {bus.byte_data, asm_lo};
  assign idx_next       = idx + IW'(1);

  // NOTE: all state below uses non-blocking assignments so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= HEADER;
      byte_cnt    <= '0;
      asm_lo      <= '0;
      count       <= '0;
      idx         <= '0;
      sum         <= '0;
      bus.wr_en   <= 1'b0;
      bus.wr_addr <= ADDR_BASE;
      bus.wr_data <= '0;
      cpu_rst     <= 1'b1;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      bus.wr_en <= 1'b0;

      if (accept) begin
        byte_cnt <= byte_cnt + 2'd1;
        case (byte_cnt)
          2'd0:    asm_lo[7:0]   <= bus.byte_data;
          2'd1:    asm_lo[15:8]  <= bus.byte_data;
          2'd2:    asm_lo[23:16] <= bus.byte_data;
          default: ;
        endcase
      end

      if (word_done) begin
        unique case (state)
          HEADER: begin
            if (word > 32'(MEM_WORDS)) begin
              state <= ERROR;
              err   <= 1'b1;
            end else if (word == 32'd0) begin
              state <= CSUM;
            end else begin
              state <= LOAD;
              count <= word[IW-1:0];
              idx   <= '0;
              sum   <= '0;
            end
          end
          LOAD: begin
            bus.wr_en   <= 1'b1;
            bus.wr_addr <= ADDR_BASE + D_WIDTH'({idx, 2'b00});
            bus.wr_data <= D_WIDTH'(word);
            sum         <= sum + word;
            idx         <= idx_next;
            if (idx_next == count) state <= CSUM;
          end
          CSUM: begin
            if (word == sum) begin
              state   <= DONE;
              done    <= 1'b1;
              cpu_rst <= 1'b0;
            end else begin
              state <= ERROR;
              err   <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_instr_loader.sv
// Randomized scoreboard bench for instr_loader: a stream-level model predicts writes and
// final status; a monitor pops expected writes whenever wr_en is seen.
module tb_instr_loader;
  localparam int MEM_WORDS = 256;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic cpu_rst, done, err;

  instr_loader_if #(.D_WIDTH(32)) bus ();

  instr_loader #(
    .D_WIDTH  (32),
    .ADDR_BASE(32'h0),
    .MEM_WORDS(MEM_WORDS)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .cpu_rst(cpu_rst),
    .done   (done),
    .err    (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] stim[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc   = 0;
  int         prev_wr = -1;
  bit         full_rate = 1'b0;
  bit         prev_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every write strobe must match the head of the expected-write queue.
  always @(negedge clk) begin
    if (rst) begin
      if (bus.wr_en) begin
        check("wr_en_single_cycle", 32'(prev_en), 32'd0);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_write: got addr %h data %h expected no write",
                   bus.wr_addr, bus.wr_data);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("wr_addr", bus.wr_addr, e.addr);
          check("wr_data", bus.wr_data, e.data);
        end
        if (full_rate && prev_wr >= 0) check("wr_spacing", 32'(cyc - prev_wr), 32'd4);
        prev_wr = cyc;
      end
      prev_en = bus.wr_en;
    end else begin
      prev_en = 1'b0;
    end
  end

  // Stream-level reference: decode the byte list directly from the format rules.
  task automatic model(output int n_acc, output bit term, output bit e_done, output bit e_err);
    int          n;
    logic [31:0] nw, s, w, c;
    n      = stim.size();
    term   = 1'b0;
    e_done = 1'b0;
    e_err  = 1'b0;
    n_acc  = n;
    if (n < 4) return;
    nw = {stim[3], stim[2], stim[1], stim[0]};
    if (nw > 32'(MEM_WORDS)) begin
      n_acc = 4;
      term  = 1'b1;
      e_err = 1'b1;
      return;
    end
    s = 0;
    for (int k = 0; k < int'(nw); k++) begin
      if (8 + 4 * k > n) return;
      w = {stim[7+4*k], stim[6+4*k], stim[5+4*k], stim[4+4*k]};
      exp_q.push_back('{addr: 32'(4 * k), data: w});
      s += w;
    end
    if (8 + 4 * int'(nw) > n) return;
    c = {stim[7+4*nw], stim[6+4*nw], stim[5+4*nw], stim[4+4*nw]};
    n_acc  = 8 + 4 * int'(nw);
    term   = 1'b1;
    e_done = (c == s);
    e_err  = (c != s);
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int b = 0; b < 4; b++) stim.push_back(w[8*b +: 8]);
  endtask

  task automatic check_status(input string tag, input bit e_done, input bit e_err, input bit e_rdy);
    check({tag, "_done"}, 32'(done), 32'(e_done));
    check({tag, "_err"}, 32'(err), 32'(e_err));
    check({tag, "_cpu_rst"}, 32'(cpu_rst), 32'(!e_done));
    check({tag, "_byte_ready"}, 32'(bus.byte_ready), 32'(e_rdy));
  endtask

  task automatic run_stream(input int gap_pct, input string tag);
    int n_acc, acc, budget, k;
    bit term, e_done, e_err, rdy, status_done;
    model(n_acc, term, e_done, e_err);
    full_rate   = (gap_pct == 0);
    prev_wr     = -1;
    acc         = 0;
    budget      = 0;
    k           = 0;
    status_done = 1'b0;
    while (k < stim.size()) begin
      @(negedge clk);
      if (term && !status_done && acc == n_acc) begin
        check_status(tag, e_done, e_err, 1'b0);
        status_done = 1'b1;
      end
      budget++;
      if (budget > 20000) begin
        n_cmp++;
        n_bad++;
        $display("FAIL %s_timeout: got %0d bytes accepted expected %0d", tag, acc, n_acc);
        break;
      end
      if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'($urandom);
        continue;
      end
      bus.byte_valid = 1'b1;
      bus.byte_data  = stim[k];
      rdy            = bus.byte_ready;
      @(posedge clk);
      if (rdy) acc++;
      k++;
    end
    @(negedge clk);
    bus.byte_valid = 1'b0;
    if (term && !status_done) check_status(tag, e_done, e_err, 1'b0);
    repeat (6) @(negedge clk);
    check({tag, "_accepted"}, 32'(acc), 32'(n_acc));
    check({tag, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
    if (term) check_status({tag, "_final"}, e_done, e_err, 1'b0);
    else      check_status({tag, "_final"}, 1'b0, 1'b0, 1'b1);
  endtask

  // Asserts reset between edges and checks outputs before any clock edge arrives.
  task automatic do_reset();
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("rst_byte_ready", 32'(bus.byte_ready), 32'd1);
    check("rst_wr_en", 32'(bus.wr_en), 32'd0);
    check("rst_wr_addr", bus.wr_addr, 32'h0);
    check("rst_wr_data", bus.wr_data, 32'h0);
    check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    exp_q.delete();
    stim.delete();
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic build_normal(input logic [31:0] csum);
    stim.delete();
    push_word(32'd2);
    push_word(32'h00500093);
    push_word(32'h00100113);
    push_word(csum);
  endtask

  initial begin
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;

    do_reset();
    build_normal(32'h006001A6);
    push_word(32'hDEADBEEF);
    run_stream(0, "normal");

    do_reset();
    push_word(32'd0);
    push_word(32'd0);
    push_word(32'h12345678);
    run_stream(0, "empty");

    do_reset();
    build_normal(32'h006001A7);
    push_word(32'hCAFEF00D);
    run_stream(0, "bad_csum");

    do_reset();
    push_word(32'(MEM_WORDS + 1));
    push_word(32'h00000013);
    push_word(32'h00000013);
    run_stream(0, "oversize");

    do_reset();
    build_normal(32'h006001A6);
    while (stim.size() > 6) void'(stim.pop_back());
    run_stream(0, "partial");
    do_reset();
    build_normal(32'h006001A6);
    run_stream(0, "after_reset");

    do_reset();
    build_normal(32'h006001A6);
    run_stream(35, "gapped");

    begin
      logic [31:0] s, w;
      do_reset();
      s = 0;
      push_word(32'(MEM_WORDS));
      for (int k = 0; k < MEM_WORDS; k++) begin
        w = $urandom;
        s += w;
        push_word(w);
      end
      push_word(s);
      run_stream(0, "max_words");
    end

    for (int t = 0; t < 8; t++) begin
      logic [31:0] s, w;
      int          n;
      do_reset();
      s = 0;
      n = int'($urandom_range(12));
      if ($urandom_range(9) == 0) push_word(32'(MEM_WORDS + 1) + $urandom_range(1000));
      else                        push_word(32'(n));
      for (int k = 0; k < n; k++) begin
        w = $urandom;
        s += w;
        push_word(w);
      end
      push_word(($urandom_range(1) == 0) ? s : s ^ (32'd1 << $urandom_range(31)));
      push_word($urandom);
      run_stream(int'($urandom_range(40)), "random");
    end

    do_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
